cpu_dbus_gate: RTL and testbench
================================

# cpu_dbus_gate

Data-side bus gate sitting directly downstream of the data MPU in the CPU memory path. Latches each CPU data request, samples the MPU's `access_deny` verdict one cycle later, then either issues the transaction on the data bus or aborts it with a protection fault. Also records the first fault's address and cause, and aborts bus transactions that never complete, through a response timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed in ISSUE plus WAIT_R before a timeout fault; legal range 1..65535.
- `clock  in  1`: sole clock, rising edge.
- `reset  in  1`: synchronous, active-high.
- `supervisor  in  1`: current privilege; sampled with the request and recorded in the fault record.
- `cpud_request  in  1`: one-cycle request pulse from the CPU.
- `cpud_write  in  1`: 1 = write, 0 = read.
- `cpud_addr  in  32`: byte address.
- `cpud_wdata  in  32`: write data.
- `cpud_wstrb  in  4`: byte enables.
- `cpud_ack  out  1`: one-cycle completion pulse.
- `cpud_fault  out  1`: qualifies `cpud_ack`; transaction aborted.
- `cpud_rdata  out  32`: read data, valid with `cpud_ack` on a non-faulting read.
- `access_deny  in  1`: MPU verdict, valid the cycle after `cpud_request`.
- `bus_request  out  1`: bus request; held until accepted.
- `bus_write  out  1`: bus direction.
- `bus_addr  out  32`: bus address.
- `bus_wdata  out  32`: bus write data.
- `bus_wstrb  out  4`: bus byte enables.
- `bus_ready  in  1`: bus accepted the request this cycle.
- `bus_rvalid  in  1`: read data valid.
- `bus_rdata  in  32`: read data.
- `fault_valid  out  1`: sticky; a fault has been recorded.
- `fault_addr  out  32`: address of the recorded fault.
- `fault_cause  out  2`: 01 = MPU deny, 10 = bus timeout.
- `fault_write  out  1`: direction of the faulting access.
- `fault_clear  in  1`: clears the fault record.

## Operation
- **States:** IDLE, CHECK, ISSUE, WAIT_R.
- **IDLE:** On `cpud_request`, register write, addr, wdata, wstrb and supervisor, then go to CHECK. `cpud_request` in any other state is ignored; a bench assertion flags it as a protocol error.
- **CHECK:** Sample `access_deny`.
  - If 1: pulse `cpud_ack` and `cpud_fault`, record cause 01, return to IDLE. No bus activity occurs.
  - If 0: go to ISSUE and clear the timeout counter.
- **ISSUE:** `bus_request` = 1 and bus outputs hold the latched values. When `bus_ready` = 1:
  - Write: pulse `cpud_ack` and go to IDLE.
  - Read: go to WAIT_R.
- **WAIT_R:** When `bus_rvalid` = 1, register `bus_rdata` into `cpud_rdata`, pulse `cpud_ack`, and go to IDLE.
- **Timeout:** The counter increments each cycle in ISSUE and WAIT_R and is `$clog2(TIMEOUT_CYCLES+1)` bits wide. When it reaches `TIMEOUT_CYCLES`, pulse `cpud_ack` and `cpud_fault`, record cause 10, and go to IDLE; `bus_request` is deasserted.
  - `bus_ready` or `bus_rvalid` in the same cycle as the timeout wins: normal completion, no fault.
- **Fault record:**
  - Loaded only when `fault_valid` = 0, so the first fault wins.
  - `fault_clear` alone: `fault_valid` = 0.
  - `fault_clear` and a new fault in the same cycle: the new fault is recorded and `fault_valid` stays 1.
- **Stray inputs:** `bus_rvalid` outside WAIT_R is ignored, including a late response after a timeout.
- **Read data:** `cpud_rdata` holds its last value between reads.

## Timing
- **Reset values:** All outputs 0. State is IDLE, the timeout counter is 0, and the fault record is cleared.
- **Reset mid-operation:** Takes effect at the next edge. `bus_request` drops that edge, with no ack.
- **Request capture:** Request in cycle N; CHECK occurs in cycle N+1.
- **MPU deny:** `cpud_ack`/`cpud_fault` = 1 in cycle N+2, and `fault_valid` = 1 from N+2.
- **Issue:** If allowed, `bus_request` = 1 from N+2. All outputs are registered.
- **Write completion:** `bus_ready` in cycle M gives `cpud_ack` in M+1. Minimum write latency is 3 cycles, request to ack.
- **Read completion:** `bus_rvalid` in cycle R gives `cpud_ack` and `cpud_rdata` in R+1.
- **Back-to-back requests:** A new request is accepted in the same cycle that `cpud_ack` is high.

## Structure
- A shared package `cpu_dbus_pkg` holds:
  - the state enum (IDLE, CHECK, ISSUE, WAIT_R);
  - the fault cause constants `FAULT_NONE`=00, `FAULT_MPU`=01, `FAULT_TIMEOUT`=10.
- One sub-module, `cpu_fault_capture`, holds the sticky first-fault record and the clear/set priority.

## Test plan
- **Allowed write:** Write to 0x0000_1000 with `access_deny`=0 and `bus_ready` in N+2 -> `bus_addr`=0x0000_1000 in N+2; `cpud_ack` in N+3 with `cpud_fault`=0.
- **Allowed read:** Read with `bus_rvalid` and `bus_rdata`=0xDEAD_BEEF 4 cycles after acceptance -> `cpud_rdata`=0xDEAD_BEEF with `cpud_ack`; `bus_request` dropped after `bus_ready`.
- **MPU deny:** Request to 0x8000_0004 with `access_deny`=1 -> `bus_request` never asserted; ack+fault in N+2; `fault_addr`=0x8000_0004, `fault_cause`=01.
- **Timeout:** `TIMEOUT_CYCLES`=4 with the bus silent -> ack+fault 4 cycles after ISSUE entry, `fault_cause`=10; a later `bus_rvalid` is ignored.
- **Second fault:** A second fault while `fault_valid`=1 -> record unchanged. `fault_clear` coinciding with a third fault -> third fault recorded.
- **Reset mid-read:** Reset asserted in WAIT_R -> next cycle all outputs 0 and state IDLE; a subsequent `bus_rvalid` produces no `cpud_ack`.

Source files
------------

// File: rtl/cpu_dbus_gate_pkg.sv
// Shared types for the data-side bus gate: FSM states and fault cause codes.
package cpu_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ISSUE  = 2'd2,
    WAIT_R = 2'd3
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t FAULT_NONE    = 2'b00;
  localparam cause_t FAULT_MPU     = 2'b01;
  localparam cause_t FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/cpu_dbus_gate_if.sv
// CPU-side request channel and downstream data-bus channel of the gate.
interface cpu_dbus_cpu_if;
  logic        cpud_request;
  logic        cpud_write;
  logic [31:0] cpud_addr;
  logic [31:0] cpud_wdata;
  logic [3:0]  cpud_wstrb;
  logic        supervisor;
  logic        cpud_ack;
  logic        cpud_fault;
  logic [31:0] cpud_rdata;

  modport master (
    output cpud_request, cpud_write, cpud_addr, cpud_wdata, cpud_wstrb, supervisor,
    input  cpud_ack, cpud_fault, cpud_rdata
  );
  modport slave (
    input  cpud_request, cpud_write, cpud_addr, cpud_wdata, cpud_wstrb, supervisor,
    output cpud_ack, cpud_fault, cpud_rdata
  );
endinterface

interface cpu_dbus_bus_if;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_request, bus_write, bus_addr, bus_wdata, bus_wstrb,
    input  bus_ready, bus_rvalid, bus_rdata
  );
  modport slave (
    input  bus_request, bus_write, bus_addr, bus_wdata, bus_wstrb,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/cpu_dbus_gate_fault_capture.sv
// Sticky first-fault record; a new fault overrides a coincident clear.
module cpu_fault_capture
  import cpu_dbus_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        set_i,
  input  logic [31:0] addr_i,
  input  cause_t      cause_i,
  input  logic        write_i,
  input  logic        super_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output cause_t      cause_o,
  output logic        write_o,
  output logic        super_o
);

  logic        valid_q;
  logic [31:0] addr_q;
  cause_t      cause_q;
  logic        write_q;
  logic        super_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      cause_q <= FAULT_NONE;
      write_q <= 1'b0;
      super_q <= 1'b0;
    end else if (set_i && (!valid_q || clear_i)) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      cause_q <= cause_i;
      write_q <= write_i;
      super_q <= super_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign cause_o = cause_q;
  assign write_o = write_q;
  assign super_o = super_q;

endmodule

// File: rtl/cpu_dbus_gate.sv
// Data bus gate: latch CPU request, apply MPU verdict, issue on the bus or
// abort with a protection/timeout fault.
module cpu_dbus_gate
  import cpu_dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  cpu_dbus_cpu_if.slave         cpu,
  cpu_dbus_bus_if.master        bus,
  input  logic                  access_deny,
  input  logic                  fault_clear,
  output logic                  fault_valid,
  output logic [31:0]           fault_addr,
  output cause_t                fault_cause,
  output logic                  fault_write,
  output logic                  fault_supervisor
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Compare against the pre-increment value so the counter never has to hold TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        write_q, super_q, ack_q, fault_q, breq_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;

  logic        timeout_hit;
  logic        flt_set;
  cause_t      flt_cause;

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    flt_set   = 1'b0;
    flt_cause = FAULT_NONE;
    case (state_q)
      CHECK: if (access_deny) begin
        flt_set   = 1'b1;
        flt_cause = FAULT_MPU;
      end
      ISSUE: if (!bus.bus_ready && timeout_hit) begin
        flt_set   = 1'b1;
        flt_cause = FAULT_TIMEOUT;
      end
      WAIT_R: if (!bus.bus_rvalid && timeout_hit) begin
        flt_set   = 1'b1;
        flt_cause = FAULT_TIMEOUT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      super_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      breq_q  <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: if (cpu.cpud_request) begin
          write_q <= cpu.cpud_write;
          addr_q  <= cpu.cpud_addr;
          wdata_q <= cpu.cpud_wdata;
          wstrb_q <= cpu.cpud_wstrb;
          super_q <= cpu.supervisor;
          state_q <= CHECK;
        end
        CHECK: begin
          cnt_q <= '0;
          if (access_deny) begin
            ack_q   <= 1'b1;
            fault_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            breq_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_d;
          if (bus.bus_ready) begin
            breq_q <= 1'b0;
            if (write_q) begin
              ack_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_R;
            end
          end else if (timeout_hit) begin
            breq_q  <= 1'b0;
            ack_q   <= 1'b1;
            fault_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        WAIT_R: begin
          cnt_q <= cnt_d;
          if (bus.bus_rvalid) begin
            rdata_q <= bus.bus_rdata;
            ack_q   <= 1'b1;
            state_q <= IDLE;
          end else if (timeout_hit) begin
            ack_q   <= 1'b1;
            fault_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu.cpud_ack   = ack_q;
  assign cpu.cpud_fault = fault_q;
  assign cpu.cpud_rdata = rdata_q;

  assign bus.bus_request = breq_q;
  assign bus.bus_write   = write_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wdata   = wdata_q;
  assign bus.bus_wstrb   = wstrb_q;

  cpu_fault_capture u_fault (
    .clock   (clock),
    .reset   (reset),
    .set_i   (flt_set),
    .addr_i  (addr_q),
    .cause_i (flt_cause),
    .write_i (write_q),
    .super_i (super_q),
    .clear_i (fault_clear),
    .valid_o (fault_valid),
    .addr_o  (fault_addr),
    .cause_o (fault_cause),
    .write_o (fault_write),
    .super_o (fault_supervisor)
  );

endmodule

// File: tb/tb_cpu_dbus_gate.sv
// Directed bench for cpu_dbus_gate with a short timeout to reach the fault paths.
module tb_cpu_dbus_gate;
  import cpu_dbus_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        access_deny = 1'b0;
  logic        fault_clear = 1'b0;
  logic        fault_valid, fault_write, fault_supervisor;
  logic [31:0] fault_addr;
  cause_t      fault_cause;
  logic        tb_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_dbus_cpu_if cpu_if ();
  cpu_dbus_bus_if bus_if ();

  cpu_dbus_gate #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu              (cpu_if),
    .bus              (bus_if),
    .access_deny      (access_deny),
    .fault_clear      (fault_clear),
    .fault_valid      (fault_valid),
    .fault_addr       (fault_addr),
    .fault_cause      (fault_cause),
    .fault_write      (fault_write),
    .fault_supervisor (fault_supervisor)
  );

  always #5 clock = ~clock;

  // Protocol: a new request is only legal while idle or in the ack cycle.
  always @(posedge clock) begin
    if (reset) tb_busy <= 1'b0;
    else begin
      if (cpu_if.cpud_request)
        assert (!tb_busy || cpu_if.cpud_ack) else $error("protocol error: request while busy");
      if (cpu_if.cpud_request) tb_busy <= 1'b1;
      else if (cpu_if.cpud_ack) tb_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives a one-cycle request in cycle N; returns positioned in cycle N+1.
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic sup);
    cpu_if.cpud_request = 1'b1;
    cpu_if.cpud_write   = wr;
    cpu_if.cpud_addr    = a;
    cpu_if.cpud_wdata   = d;
    cpu_if.cpud_wstrb   = s;
    cpu_if.supervisor   = sup;
    step();
    cpu_if.cpud_request = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_if.cpud_request = 1'b0;
    cpu_if.cpud_write   = 1'b0;
    cpu_if.cpud_addr    = '0;
    cpu_if.cpud_wdata   = '0;
    cpu_if.cpud_wstrb   = '0;
    cpu_if.supervisor   = 1'b0;
    bus_if.bus_ready    = 1'b0;
    bus_if.bus_rvalid   = 1'b0;
    bus_if.bus_rdata    = '0;

    step(); step();
    chk("rst_ack",   cpu_if.cpud_ack, 0);
    chk("rst_fault", cpu_if.cpud_fault, 0);
    chk("rst_breq",  bus_if.bus_request, 0);
    chk("rst_rdata", cpu_if.cpud_rdata, 0);
    chk("rst_baddr", bus_if.bus_addr, 0);
    chk("rst_fv",    fault_valid, 0);
    reset = 1'b0;
    step();

    // allowed write, bus_ready in N+2
    req(1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'h3, 1'b1);
    chk("wr_n1_breq", bus_if.bus_request, 0);
    step();
    chk("wr_breq",  bus_if.bus_request, 1);
    chk("wr_addr",  bus_if.bus_addr, 32'h0000_1000);
    chk("wr_wdata", bus_if.bus_wdata, 32'hA5A5_0001);
    chk("wr_wstrb", bus_if.bus_wstrb, 4'h3);
    chk("wr_dir",   bus_if.bus_write, 1);
    bus_if.bus_ready = 1'b1; step(); bus_if.bus_ready = 1'b0;
    chk("wr_ack",   cpu_if.cpud_ack, 1);
    chk("wr_fault", cpu_if.cpud_fault, 0);
    chk("wr_breq_drop", bus_if.bus_request, 0);
    step();
    chk("wr_ack_pulse", cpu_if.cpud_ack, 0);

    // allowed read, rvalid in N+4
    req(1'b0, 32'h0000_2000, 32'h0, 4'hF, 1'b0);
    step();
    chk("rd_breq", bus_if.bus_request, 1);
    chk("rd_dir",  bus_if.bus_write, 0);
    bus_if.bus_ready = 1'b1; step(); bus_if.bus_ready = 1'b0;
    chk("rd_breq_drop", bus_if.bus_request, 0);
    chk("rd_early_ack", cpu_if.cpud_ack, 0);
    step();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    step();
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    chk("rd_ack",   cpu_if.cpud_ack, 1);
    chk("rd_fault", cpu_if.cpud_fault, 0);
    chk("rd_data",  cpu_if.cpud_rdata, 32'hDEAD_BEEF);
    step();
    chk("rd_hold",      cpu_if.cpud_rdata, 32'hDEAD_BEEF);
    chk("rd_ack_pulse", cpu_if.cpud_ack, 0);

    // MPU deny
    req(1'b0, 32'h8000_0004, 32'h0, 4'hF, 1'b1);
    access_deny = 1'b1;
    chk("dn_breq_n1", bus_if.bus_request, 0);
    step();
    access_deny = 1'b0;
    chk("dn_ack",    cpu_if.cpud_ack, 1);
    chk("dn_fault",  cpu_if.cpud_fault, 1);
    chk("dn_breq",   bus_if.bus_request, 0);
    chk("dn_fv",     fault_valid, 1);
    chk("dn_faddr",  fault_addr, 32'h8000_0004);
    chk("dn_cause",  fault_cause, FAULT_MPU);
    chk("dn_fwrite", fault_write, 0);
    chk("dn_super",  fault_supervisor, 1);
    step();
    chk("dn_breq_n3",  bus_if.bus_request, 0);
    chk("dn_ack_pulse", cpu_if.cpud_ack, 0);

    // read whose rvalid lands on the last allowed cycle: completion wins
    req(1'b0, 32'h0000_2400, 32'h0, 4'hF, 1'b0);
    step();
    bus_if.bus_ready = 1'b1; step(); bus_if.bus_ready = 1'b0;
    step(); step();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    step();
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    chk("bd_ack",   cpu_if.cpud_ack, 1);
    chk("bd_fault", cpu_if.cpud_fault, 0);
    chk("bd_data",  cpu_if.cpud_rdata, 32'h1234_5678);
    chk("bd_faddr", fault_addr, 32'h8000_0004);

    // clear alone
    fault_clear = 1'b1; step(); fault_clear = 1'b0;
    chk("clr_fv", fault_valid, 0);

    // timeout on a silent bus: ISSUE entered in N+2, ack+fault in N+6
    req(1'b1, 32'h0000_3000, 32'h0000_0011, 4'hF, 1'b0);
    step();
    chk("to_breq", bus_if.bus_request, 1);
    step(); step(); step();
    chk("to_breq_n5", bus_if.bus_request, 1);
    chk("to_ack_n5",  cpu_if.cpud_ack, 0);
    step();
    chk("to_ack",    cpu_if.cpud_ack, 1);
    chk("to_fault",  cpu_if.cpud_fault, 1);
    chk("to_breq_off", bus_if.bus_request, 0);
    chk("to_fv",     fault_valid, 1);
    chk("to_cause",  fault_cause, FAULT_TIMEOUT);
    chk("to_faddr",  fault_addr, 32'h0000_3000);
    chk("to_fwrite", fault_write, 1);
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h0000_0BAD;
    step();
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    chk("late_ack",   cpu_if.cpud_ack, 0);
    chk("late_rdata", cpu_if.cpud_rdata, 32'h1234_5678);

    // second fault leaves the record alone
    req(1'b1, 32'h0000_4000, 32'h0, 4'hF, 1'b1);
    access_deny = 1'b1; step(); access_deny = 1'b0;
    chk("f2_ack",   cpu_if.cpud_ack, 1);
    chk("f2_fault", cpu_if.cpud_fault, 1);
    chk("f2_faddr", fault_addr, 32'h0000_3000);
    chk("f2_cause", fault_cause, FAULT_TIMEOUT);

    // third fault coincident with clear is recorded
    req(1'b0, 32'h0000_5000, 32'h0, 4'hF, 1'b0);
    access_deny = 1'b1; fault_clear = 1'b1;
    step();
    access_deny = 1'b0; fault_clear = 1'b0;
    chk("f3_fv",     fault_valid, 1);
    chk("f3_faddr",  fault_addr, 32'h0000_5000);
    chk("f3_cause",  fault_cause, FAULT_MPU);
    chk("f3_fwrite", fault_write, 0);
    chk("f3_super",  fault_supervisor, 0);

    // reset while waiting for read data
    req(1'b0, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
    step();
    bus_if.bus_ready = 1'b1; step(); bus_if.bus_ready = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    chk("rs_ack",   cpu_if.cpud_ack, 0);
    chk("rs_fault", cpu_if.cpud_fault, 0);
    chk("rs_breq",  bus_if.bus_request, 0);
    chk("rs_rdata", cpu_if.cpud_rdata, 0);
    chk("rs_baddr", bus_if.bus_addr, 0);
    chk("rs_fv",    fault_valid, 0);
    chk("rs_faddr", fault_addr, 0);
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h0000_0077;
    step();
    bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    chk("rs_late_ack", cpu_if.cpud_ack, 0);
    step();
    chk("rs_late_ack2", cpu_if.cpud_ack, 0);
    chk("rs_late_rdata", cpu_if.cpud_rdata, 0);

    // gate is back in IDLE: a denied request completes on schedule
    req(1'b1, 32'h0000_7000, 32'h0, 4'hF, 1'b1);
    access_deny = 1'b1; step(); access_deny = 1'b0;
    chk("rs_idle_ack",   cpu_if.cpud_ack, 1);
    chk("rs_idle_faddr", fault_addr, 32'h0000_7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
